ucom_multi_timer: RTL and testbench
===================================

Name: ucom_multi_timer

Overview:
- Parametrised successor to the single STM/TM interval timer in the MCU core.
- Provides NCH independent channels. Each channel has a prescaler (polynomial-style, all-ones terminal), a down-counter, one-shot or auto-reload mode, a sticky flag, and a maskable interrupt request.
- Sits beside the core datapath. The core loads it from STM/LDI-style parameter cycles, tests flags with TTM-style skips, and feeds `irq` into the interrupt logic.

Parameters:
- NCH, 2: number of timer channels (1..8).
- PRE_W, 6: prescaler width; one counter decrement every 2^PRE_W enabled ticks.
- CNT_W, 6: down-counter and load-value width.
- CH_W, $clog2(NCH) (min 1): channel index width (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  tick enable (core clk_en); all channel activity is gated by en
- ld  in  1  load strobe, sampled when en=1
- ld_ch  in  CH_W  channel to load
- ld_val  in  CNT_W  initial count
- ld_auto  in  1  1 = auto-reload mode, 0 = one-shot
- stop  in  1  halt strobe, sampled when en=1
- stop_ch  in  CH_W  channel to halt
- clr  in  1  flag-clear strobe, sampled when en=1
- clr_ch  in  CH_W  channel whose flag is cleared
- ien  in  NCH  per-channel interrupt enable
- rd_ch  in  CH_W  read-back channel select
- rd_cnt  out  CNT_W  current count of channel rd_ch (combinational mux)
- flag  out  NCH  sticky expiry flags (TM equivalent)
- run  out  NCH  channel-running status
- irq  out  1  OR over (flag & ien), registered

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset state: all of cnt, reload, pre, run, mode, flag = 0; irq = 0; rd_cnt = 0.
- Gating: no state changes when en=0.
- Per-channel state: pre[PRE_W], cnt[CNT_W], reload[CNT_W], mode, run, flag.
- Load (en & ld, channel k):
  - pre <= 0, cnt <= ld_val, reload <= ld_val, mode <= ld_auto, run <= 1.
  - Load does not touch the flag; a pending flag stays until cleared.
- Running tick (en & run, no load on that channel): pre <= pre+1 (wraps).
  - If pre == all-ones and cnt != 0: cnt <= cnt-1.
  - If pre == all-ones and cnt == 0 (expiry):
    - flag <= 1.
    - mode=1: cnt <= reload, run stays 1.
    - mode=0: cnt stays 0, run <= 0, pre <= 0.
- Expiry timing: (ld_val+1) × 2^PRE_W enabled ticks after the load cycle. flag is visible on the cycle after the expiring tick.
- Stop (en & stop, channel k): run <= 0. pre, cnt and flag hold. A later load restarts the channel.
- Clear (en & clr, channel k): flag <= 0.
- Priority within one en cycle, same channel:
  - Load beats stop. Load beats the running tick, so no expiry fires on a load cycle.
  - Expiry set beats clear, so no event is lost.
  - Stop and expiry together: the flag is set and run <= 0.
- Different channels addressed by ld/stop/clr in the same cycle act independently.
- irq: irq <= |(flag & ien) each clk regardless of en. One-cycle latency from a flag or ien change.
- Index range: out-of-range ld_ch/stop_ch/clr_ch (≥ NCH) are ignored. An out-of-range rd_ch returns 0.
- Width rules:
  - cnt/pre arithmetic is modulo 2^width.
  - ld_val = 0 expires after exactly 2^PRE_W ticks.
  - ld_val = all-ones gives the maximum period 2^(CNT_W+PRE_W).
- Reset mid-count: reset wins over every strobe in the same cycle and returns all channels to idle.

Decomposition:
- Shared package `ucom_pkg`:
  - Default widths (PRE_W=6, CNT_W=6).
  - Mode encoding (MODE_ONESHOT=0, MODE_AUTO=1).
  - The STM opcode constant, so the core and the timer decode it identically.
- One natural sub-module, `ucom_timer_ch`: the single channel (prescaler, counter, mode, run, flag, priority logic), instantiated NCH times by a generate loop.
- The top level handles strobe decode, the rd_cnt mux and the irq register.

Test Plan:
- Reset then load ch0 ld_val=0 one-shot, en constantly 1 -> flag[0] rises after exactly 64 ticks; run[0]=0; rd_cnt=0 thereafter.
- Load ch1 ld_val=2 auto-reload, ien=2'b10 -> flag[1] and irq at tick 192. rd_cnt(ch1) reads 2 after expiry and run[1] stays 1. Clear at tick 200 drops irq one cycle later. Flag sets again at tick 384.
- en toggled 1-of-4 cycles, ch0 ld_val=1 -> flag after 128 enabled ticks (512 clk). No state change observed on en=0 cycles.
- Clear asserted on the exact expiry cycle of ch0 -> flag[0]=1 (set wins). Load on the same expiry cycle -> flag unchanged, cnt=ld_val, pre=0.
- Stop ch0 mid-count at cnt=3 -> cnt holds 3 for 1000 ticks and flag stays 0. A subsequent load ld_val=5 restarts the channel with expiry 384 ticks later.
- Assert reset while both channels run with flags set -> next cycle all outputs 0; ld_ch=3 with NCH=2 has no effect.

Source files
------------

// File: rtl/ucom_pkg.sv
// Shared constants for the multi-channel interval timer and the core that drives it.
package ucom_pkg;

    localparam int PRE_W_DEF = 6;
    localparam int CNT_W_DEF = 6;

    // Opcode shared with the core decoder so both sides agree on the STM encoding.
    localparam logic [7:0] OP_STM = 8'h57;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_AUTO    = 1'b1
    } mode_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ucom_multi_timer_if.sv
// Core-side strobe/readback bundle for ucom_multi_timer.
interface ucom_multi_timer_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 6,
    parameter int CH_W  = 1
) ();
    logic             en;
    logic             ld;
    logic [CH_W-1:0]  ld_ch;
    logic [CNT_W-1:0] ld_val;
    logic             ld_auto;
    logic             stop;
    logic [CH_W-1:0]  stop_ch;
    logic             clr;
    logic [CH_W-1:0]  clr_ch;
    logic [NCH-1:0]   ien;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_cnt;
    logic [NCH-1:0]   flag;
    logic [NCH-1:0]   run;
    logic             irq;

    modport master (
        output en, ld, ld_ch, ld_val, ld_auto, stop, stop_ch, clr, clr_ch, ien, rd_ch,
        input  rd_cnt, flag, run, irq
    );

    modport slave (
        input  en, ld, ld_ch, ld_val, ld_auto, stop, stop_ch, clr, clr_ch, ien, rd_ch,
        output rd_cnt, flag, run, irq
    );
endinterface

// File: rtl/ucom_timer_ch.sv
// One timer channel: prescaler, down-counter, one-shot/auto-reload, sticky flag.
module ucom_timer_ch
    import ucom_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             ld_auto,
    input  logic             stop,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             flag,
    output logic             run
);

    logic [PRE_W-1:0] pre, pre_n;
    logic [CNT_W-1:0] reload, reload_n, cnt_n;
    mode_e            mode, mode_n;
    logic             run_n, flag_n, expire;

    always_comb begin
        pre_n    = pre;
        cnt_n    = cnt;
        reload_n = reload;
        mode_n   = mode;
        run_n    = run;
        flag_n   = flag;
        expire   = 1'b0;
        if (en) begin
            if (ld) begin
                pre_n    = '0;
                cnt_n    = ld_val;
                reload_n = ld_val;
                mode_n   = ld_auto ? MODE_AUTO : MODE_ONESHOT;
                run_n    = 1'b1;
            end else if (run) begin
                expire = (&pre) && (cnt == '0);
                // A stop freezes pre/cnt but an expiry on the same tick still sets the flag.
                if (stop) begin
                    run_n = 1'b0;
                end else begin
                    pre_n = pre + PRE_W'(1);
                    if (&pre) begin
                        if (cnt != '0) begin
                            cnt_n = cnt - CNT_W'(1);
                        end else if (mode == MODE_AUTO) begin
                            cnt_n = reload;
                        end else begin
                            run_n = 1'b0;
                            pre_n = '0;
                        end
                    end
                end
            end
            if (expire)   flag_n = 1'b1;
            else if (clr) flag_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre    <= '0;
            cnt    <= '0;
            reload <= '0;
            mode   <= MODE_ONESHOT;
            run    <= 1'b0;
            flag   <= 1'b0;
        end else begin
            pre    <= pre_n;
            cnt    <= cnt_n;
            reload <= reload_n;
            mode   <= mode_n;
            run    <= run_n;
            flag   <= flag_n;
        end
    end

endmodule

// File: rtl/ucom_multi_timer.sv
// NCH-channel interval timer: strobe decode, count readback mux and registered irq.
module ucom_multi_timer
    import ucom_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int PRE_W = PRE_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = ch_width(NCH)
) (
    input logic               clk,
    input logic               reset,
    ucom_multi_timer_if.slave bus
);

    logic [CNT_W-1:0] cnt_all [NCH];
    logic [NCH-1:0]   flag_v;
    logic [NCH-1:0]   run_v;
    logic [CNT_W-1:0] rd_mux;
    logic             irq_q;

    // Out-of-range channel indices never match any instance and are dropped here.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ucom_timer_ch #(
            .PRE_W (PRE_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.en),
            .ld      (bus.ld   && (bus.ld_ch   == CH_W'(k))),
            .ld_val  (bus.ld_val),
            .ld_auto (bus.ld_auto),
            .stop    (bus.stop && (bus.stop_ch == CH_W'(k))),
            .clr     (bus.clr  && (bus.clr_ch  == CH_W'(k))),
            .cnt     (cnt_all[k]),
            .flag    (flag_v[k]),
            .run     (run_v[k])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.rd_ch == CH_W'(i)) rd_mux = cnt_all[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |(flag_v & bus.ien);
    end

    assign bus.rd_cnt = rd_mux;
    assign bus.flag   = flag_v;
    assign bus.run    = run_v;
    assign bus.irq    = irq_q;

endmodule

// File: tb/tb_ucom_multi_timer.sv
// Directed bench for ucom_multi_timer with an elapsed-tick reference model.
module tb_ucom_multi_timer;

    localparam int NCH   = 3;
    localparam int PRE_W = 6;
    localparam int CNT_W = 6;
    localparam int CH_W  = 2;
    localparam int PSC   = 1 << PRE_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ucom_multi_timer_if #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    ucom_multi_timer #(
        .NCH   (NCH),
        .PRE_W (PRE_W),
        .CNT_W (CNT_W),
        .CH_W  (CH_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: each channel is described by its load value and the number of
    // enabled running ticks elapsed since the load.
    int mv [NCH];
    int me [NCH];
    bit mauto [NCH];
    bit mrun [NCH];
    bit mflag [NCH];
    bit mirq;

    function automatic int model_cnt(input int ch);
        int p;
        if (ch >= NCH) return 0;
        p = (mv[ch] + 1) * PSC;
        return mv[ch] - (me[ch] % p) / PSC;
    endfunction

    always @(posedge clk) begin
        bit any;
        any = 1'b0;
        for (int i = 0; i < NCH; i++) any |= mflag[i] & bus.ien[i];
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                mv[i] = 0; me[i] = 0; mauto[i] = 0; mrun[i] = 0; mflag[i] = 0;
            end
            mirq = 1'b0;
        end else begin
            mirq = any;
            if (bus.en) begin
                for (int i = 0; i < NCH; i++) begin
                    bit hl, hs, hc, ex;
                    hl = bus.ld   && (int'(bus.ld_ch)   == i);
                    hs = bus.stop && (int'(bus.stop_ch) == i);
                    hc = bus.clr  && (int'(bus.clr_ch)  == i);
                    ex = 1'b0;
                    if (hl) begin
                        mv[i] = int'(bus.ld_val); me[i] = 0; mauto[i] = bus.ld_auto; mrun[i] = 1'b1;
                    end else if (mrun[i]) begin
                        ex = ((me[i] + 1) % ((mv[i] + 1) * PSC)) == 0;
                        if (hs) begin
                            mrun[i] = 1'b0;
                        end else begin
                            me[i]++;
                            if (ex && !mauto[i]) begin
                                mrun[i] = 1'b0; mv[i] = 0; me[i] = 0;
                            end
                        end
                    end
                    if (ex)      mflag[i] = 1'b1;
                    else if (hc) mflag[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [NCH-1:0] fv, rv;
            for (int i = 0; i < NCH; i++) begin fv[i] = mflag[i]; rv[i] = mrun[i]; end
            chk("model_flag", 32'(bus.flag), 32'(fv));
            chk("model_run", 32'(bus.run), 32'(rv));
            chk("model_irq", 32'(bus.irq), 32'(mirq));
            chk("model_rd_cnt", 32'(bus.rd_cnt), 32'(model_cnt(int'(bus.rd_ch))));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int ch, input int val, input bit auto_m);
        bus.ld = 1'b1; bus.ld_ch = CH_W'(ch); bus.ld_val = CNT_W'(val); bus.ld_auto = auto_m;
        step(1);
        bus.ld = 1'b0;
    endtask

    task automatic clear(input int ch);
        bus.clr = 1'b1; bus.clr_ch = CH_W'(ch);
        step(1);
        bus.clr = 1'b0;
    endtask

    task automatic halt(input int ch);
        bus.stop = 1'b1; bus.stop_ch = CH_W'(ch);
        step(1);
        bus.stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b1; bus.ld = 1'b0; bus.ld_ch = '0; bus.ld_val = '0; bus.ld_auto = 1'b0;
        bus.stop = 1'b0; bus.stop_ch = '0; bus.clr = 1'b0; bus.clr_ch = '0;
        bus.ien = '0; bus.rd_ch = '0;
        step(2);
        chk_on = 1'b1;
        chk("reset_flag", 32'(bus.flag), 0);
        chk("reset_run", 32'(bus.run), 0);
        chk("reset_irq", 32'(bus.irq), 0);
        chk("reset_rd_cnt", 32'(bus.rd_cnt), 0);
        reset = 1'b0;

        // ld_val=0 one-shot expires after exactly 64 ticks
        load(0, 0, 0);
        step(63);
        chk("t1_flag_before", 32'(bus.flag[0]), 0);
        step(1);
        chk("t1_flag_at64", 32'(bus.flag[0]), 1);
        chk("t1_run_off", 32'(bus.run[0]), 0);
        step(5);
        chk("t1_cnt_zero", 32'(bus.rd_cnt), 0);
        clear(0);

        // auto-reload ch1, value 2: period 192 ticks
        bus.ien = 3'b010; bus.rd_ch = 2'd1;
        load(1, 2, 1);
        step(191);
        chk("t2_flag_before", 32'(bus.flag[1]), 0);
        step(1);
        chk("t2_flag_at192", 32'(bus.flag[1]), 1);
        chk("t2_irq_lag", 32'(bus.irq), 0);
        step(1);
        chk("t2_irq", 32'(bus.irq), 1);
        chk("t2_reload_cnt", 32'(bus.rd_cnt), 2);
        chk("t2_run_kept", 32'(bus.run[1]), 1);
        step(6);
        clear(1);
        chk("t2_flag_cleared", 32'(bus.flag[1]), 0);
        chk("t2_irq_still", 32'(bus.irq), 1);
        step(1);
        chk("t2_irq_dropped", 32'(bus.irq), 0);
        step(182);
        chk("t2_flag2_before", 32'(bus.flag[1]), 0);
        step(1);
        chk("t2_flag_at384", 32'(bus.flag[1]), 1);
        halt(1);
        clear(1);
        bus.ien = '0;

        // en active 1-of-4 cycles; a load strobe while en=0 must be ignored
        bus.rd_ch = 2'd0;
        load(0, 1, 0);
        bus.ld = 1'b1; bus.ld_ch = 2'd2; bus.ld_val = 6'd7;
        repeat (127) begin
            bus.en = 1'b0; step(3);
            bus.ld = 1'b0;
            bus.en = 1'b1; step(1);
        end
        chk("t3_flag_before", 32'(bus.flag[0]), 0);
        chk("t3_gated_load", 32'(bus.run[2]), 0);
        bus.en = 1'b0; step(3);
        bus.en = 1'b1; step(1);
        chk("t3_flag_at128", 32'(bus.flag[0]), 1);
        clear(0);

        // clear on expiry cycle: set wins
        load(0, 0, 0);
        step(63);
        clear(0);
        chk("t4_set_beats_clr", 32'(bus.flag[0]), 1);
        clear(0);
        // load on expiry cycle: no expiry, restart from ld_val
        load(0, 0, 1);
        step(63);
        load(0, 3, 0);
        chk("t4_ld_no_flag", 32'(bus.flag[0]), 0);
        chk("t4_ld_cnt", 32'(bus.rd_cnt), 3);
        step(255);
        chk("t4_reexp_before", 32'(bus.flag[0]), 0);
        step(1);
        chk("t4_reexp_at256", 32'(bus.flag[0]), 1);
        clear(0);

        // stop at cnt=3, hold, then restart
        load(0, 5, 0);
        step(128);
        chk("t5_cnt3", 32'(bus.rd_cnt), 3);
        halt(0);
        step(1000);
        chk("t5_cnt_held", 32'(bus.rd_cnt), 3);
        chk("t5_flag_held", 32'(bus.flag[0]), 0);
        chk("t5_run_off", 32'(bus.run[0]), 0);
        load(0, 5, 0);
        step(383);
        chk("t5_flag_before", 32'(bus.flag[0]), 0);
        step(1);
        chk("t5_flag_at384", 32'(bus.flag[0]), 1);

        // reset mid-count with flags pending, then out-of-range index
        bus.ien = 3'b011;
        load(0, 0, 1);
        load(1, 0, 1);
        step(70);
        chk("t6_irq_pre", 32'(bus.irq), 1);
        chk("t6_run_pre", 32'(bus.run), 3);
        reset = 1'b1;
        bus.ld = 1'b1; bus.ld_ch = 2'd0; bus.ld_val = 6'd5; bus.clr = 1'b1; bus.clr_ch = 2'd1;
        step(1);
        bus.clr = 1'b0;
        chk("t6_rst_flag", 32'(bus.flag), 0);
        chk("t6_rst_run", 32'(bus.run), 0);
        chk("t6_rst_irq", 32'(bus.irq), 0);
        chk("t6_rst_cnt", 32'(bus.rd_cnt), 0);
        reset = 1'b0;
        bus.ld_ch = 2'd3;
        step(1);
        bus.ld = 1'b0;
        chk("t6_oor_load", 32'(bus.run), 0);
        load(2, 9, 0);
        bus.rd_ch = 2'd3;
        step(1);
        chk("t6_oor_rd", 32'(bus.rd_cnt), 0);
        bus.rd_ch = 2'd2;
        step(1);
        chk("t6_rd_ch2", 32'(bus.rd_cnt), 9);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
